// File: rtl/ddr_layer_cfg_fetch_if.sv
// Config-read request/response and DMA descriptor bus.
// master: drives rd_req_*, desc_*; samples rd_rsp_*, ready inputs.
interface ddr_layer_cfg_fetch_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 128,
   parameter int LEN_W  = 24
);
   logic              rd_req_valid;
   logic              rd_req_ready;
   logic [ADDR_W-1:0] rd_req_addr;
   logic              rd_rsp_valid;
   logic [DATA_W-1:0] rd_rsp_data;
   logic              desc_valid;
   logic              desc_ready;
   logic [1:0]        desc_type;
   logic [ADDR_W-1:0] desc_addr;
   logic [LEN_W-1:0]  desc_len;

   modport master (
      output rd_req_valid, rd_req_addr,
      input  rd_req_ready,
      input  rd_rsp_valid, rd_rsp_data,
      output desc_valid, desc_type, desc_addr, desc_len,
      input  desc_ready
   );

   modport slave (
      input  rd_req_valid, rd_req_addr,
      output rd_req_ready,
      output rd_rsp_valid, rd_rsp_data,
      input  desc_valid, desc_type, desc_addr, desc_len,
      output desc_ready
   );
endinterface

// File: rtl/ddr_layer_cfg_fetch.sv
// Walks the per-layer config table in DDR, emits ACT/FLGACT/WEI/FLGWEI
// read descriptors per layer, then waits for layer_done; zero slot ends.
// Ports: clk, rst (sync, active-high), start, bus (master: config read
// and descriptor handshakes), layer_done, decoded cfg_* outputs,
// layer_idx, busy, all_done.
module ddr_layer_cfg_fetch #(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 128,
   parameter int                LEN_W       = 24,
   parameter logic [ADDR_W-1:0] CFG_ADDR    = 32'h0800_0000,
   parameter logic [ADDR_W-1:0] ACT_BASE    = 32'h0810_0000,
   parameter logic [ADDR_W-1:0] FLGACT_BASE = 32'h0890_0000,
   parameter logic [ADDR_W-1:0] WEI_BASE    = 32'h08A0_0000,
   parameter logic [ADDR_W-1:0] FLGWEI_BASE = 32'h0920_0000,
   parameter logic [LEN_W-1:0]  ACT_LEN     = 24'h80_0000,
   parameter logic [LEN_W-1:0]  FLG_LEN     = 24'h10_0000,
   parameter logic [LEN_W-1:0]  WEI_LEN     = 24'h80_0000,
   parameter int                MAX_LAYERS  = 256,
   localparam int               IDX_W       = $clog2(MAX_LAYERS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   ddr_layer_cfg_fetch_if.master bus,
   input  logic                 layer_done,
   output logic                 cfg_valid,
   output logic [DATA_W-1:0]    cfg_word,
   output logic [2:0]           cfg_stride,
   output logic                 cfg_pool_valifm,
   output logic [7:0]           cfg_bias_y,
   output logic [19:0]          cfg_scale_y,
   output logic [7:0]           cfg_pool,
   output logic [8:0]           cfg_num_lay,
   output logic [IDX_W-1:0]     layer_idx,
   output logic                 busy,
   output logic                 all_done
);

   typedef enum logic [2:0] {
      IDLE, CFG_REQ, CFG_WAIT, DESC, CFG_OUT, RUN, FINISH
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  layer_idx_q, layer_idx_d;
   logic [DATA_W-1:0] cfg_word_q, cfg_word_d;
   logic [1:0]        desc_cnt_q, desc_cnt_d;
   logic              desc_valid_q, desc_valid_d;
   logic [ADDR_W-1:0] desc_addr_q, desc_addr_d;
   logic [LEN_W-1:0]  desc_len_q, desc_len_d;
   logic              done_seen_q, done_seen_d;
   logic              all_done_q, all_done_d;
   logic              rd_req_valid;
   logic              desc_hs;
   logic              last_layer;

   function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] d);
      logic [ADDR_W-1:0] b;
      case (d)
         2'd0:    b = ACT_BASE;
         2'd1:    b = FLGACT_BASE;
         2'd2:    b = WEI_BASE;
         default: b = FLGWEI_BASE;
      endcase
      return b;
   endfunction

   function automatic logic [LEN_W-1:0] len_of(input logic [1:0] d);
      logic [LEN_W-1:0] l;
      case (d)
         2'd0:    l = ACT_LEN;
         2'd2:    l = WEI_LEN;
         default: l = FLG_LEN;
      endcase
      return l;
   endfunction

   // Region start wraps modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] addr_of(
      input logic [1:0]       d,
      input logic [IDX_W-1:0] idx
   );
      return base_of(d) + ADDR_W'(idx) * ADDR_W'(len_of(d));
   endfunction

   assign desc_hs    = desc_valid_q && bus.desc_ready;
   assign last_layer = (layer_idx_q == IDX_W'(MAX_LAYERS - 1));

   always_comb begin
      state_d      = state_q;
      layer_idx_d  = layer_idx_q;
      cfg_word_d   = cfg_word_q;
      desc_cnt_d   = desc_cnt_q;
      desc_valid_d = desc_valid_q;
      desc_addr_d  = desc_addr_q;
      desc_len_d   = desc_len_q;
      done_seen_d  = done_seen_q;
      all_done_d   = 1'b0;
      rd_req_valid = 1'b0;
      cfg_valid    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               layer_idx_d = '0;
               done_seen_d = 1'b0;
               state_d     = CFG_REQ;
            end
         end
         CFG_REQ: begin
            rd_req_valid = 1'b1;
            if (bus.rd_req_ready) state_d = CFG_WAIT;
         end
         CFG_WAIT: begin
            if (bus.rd_rsp_valid) begin
               cfg_word_d = bus.rd_rsp_data;
               if (bus.rd_rsp_data == '0) begin
                  state_d = FINISH;
               end else begin
                  state_d      = DESC;
                  desc_cnt_d   = 2'd0;
                  desc_valid_d = 1'b1;
                  desc_addr_d  = addr_of(2'd0, layer_idx_q);
                  desc_len_d   = len_of(2'd0);
               end
            end
         end
         DESC: begin
            if (layer_done) done_seen_d = 1'b1;
            if (desc_hs) begin
               if (desc_cnt_q == 2'd3) begin
                  desc_cnt_d   = 2'd0;
                  desc_valid_d = 1'b0;
                  desc_addr_d  = '0;
                  desc_len_d   = '0;
                  state_d      = CFG_OUT;
               end else begin
                  desc_cnt_d  = desc_cnt_q + 2'd1;
                  desc_addr_d = addr_of(desc_cnt_q + 2'd1, layer_idx_q);
                  desc_len_d  = len_of(desc_cnt_q + 2'd1);
               end
            end
         end
         CFG_OUT: begin
            cfg_valid = 1'b1;
            if (layer_done) done_seen_d = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            if (layer_done || done_seen_q) begin
               done_seen_d = 1'b0;
               if (last_layer) begin
                  state_d = FINISH;
               end else begin
                  layer_idx_d = layer_idx_q + IDX_W'(1);
                  state_d     = CFG_REQ;
               end
            end
         end
         FINISH: begin
            all_done_d = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         layer_idx_q  <= '0;
         cfg_word_q   <= '0;
         desc_cnt_q   <= '0;
         desc_valid_q <= 1'b0;
         desc_addr_q  <= '0;
         desc_len_q   <= '0;
         done_seen_q  <= 1'b0;
         all_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         layer_idx_q  <= layer_idx_d;
         cfg_word_q   <= cfg_word_d;
         desc_cnt_q   <= desc_cnt_d;
         desc_valid_q <= desc_valid_d;
         desc_addr_q  <= desc_addr_d;
         desc_len_q   <= desc_len_d;
         done_seen_q  <= done_seen_d;
         all_done_q   <= all_done_d;
      end
   end

   assign bus.rd_req_valid = rd_req_valid;
   assign bus.rd_req_addr  = CFG_ADDR + ADDR_W'({layer_idx_q, 4'b0});
   assign bus.desc_valid   = desc_valid_q;
   assign bus.desc_type    = desc_cnt_q;
   assign bus.desc_addr    = desc_addr_q;
   assign bus.desc_len     = desc_len_q;

   assign cfg_word        = cfg_word_q;
   assign cfg_stride      = cfg_word_q[2:0];
   assign cfg_pool_valifm = cfg_word_q[3];
   assign cfg_bias_y      = cfg_word_q[11:4];
   assign cfg_scale_y     = cfg_word_q[31:12];
   assign cfg_pool        = cfg_word_q[39:32];
   assign cfg_num_lay     = cfg_word_q[48:40];
   assign layer_idx       = layer_idx_q;
   assign busy            = (state_q != IDLE);
   assign all_done        = all_done_q;

endmodule

// File: tb/tb_ddr_layer_cfg_fetch.sv
// Bench for ddr_layer_cfg_fetch: random DDR/DMA agents against a
// table-walk reference model of the expected reads, descriptors, configs.
module tb_ddr_layer_cfg_fetch;
   localparam logic [31:0] CFG_ADDR = 32'h0800_0000;
   localparam logic [31:0] BASES [4] = '{32'h0810_0000, 32'h0890_0000,
                                         32'h08A0_0000, 32'h0920_0000};
   localparam logic [23:0] LENS [4] = '{24'h80_0000, 24'h10_0000,
                                        24'h80_0000, 24'h10_0000};

   typedef struct packed {
      logic [1:0]  t;
      logic [31:0] a;
      logic [23:0] l;
   } desc_t;

   typedef struct packed {
      logic [127:0] w;
      logic [2:0]   stride;
      logic         valifm;
      logic [7:0]   bias;
      logic [19:0]  scale;
      logic [7:0]   pool;
      logic [8:0]   num;
      logic [7:0]   idx;
   } cfg_t;

   logic         clk = 1'b0;
   logic         rst, start, layer_done;
   logic         cfg_valid;
   logic [127:0] cfg_word;
   logic [2:0]   cfg_stride;
   logic         cfg_pool_valifm;
   logic [7:0]   cfg_bias_y;
   logic [19:0]  cfg_scale_y;
   logic [7:0]   cfg_pool;
   logic [8:0]   cfg_num_lay;
   logic [7:0]   layer_idx;
   logic         busy, all_done;

   ddr_layer_cfg_fetch_if #(.ADDR_W(32), .DATA_W(128), .LEN_W(24)) bus ();

   ddr_layer_cfg_fetch dut (
      .clk(clk), .rst(rst), .start(start), .bus(bus),
      .layer_done(layer_done), .cfg_valid(cfg_valid),
      .cfg_word(cfg_word), .cfg_stride(cfg_stride),
      .cfg_pool_valifm(cfg_pool_valifm), .cfg_bias_y(cfg_bias_y),
      .cfg_scale_y(cfg_scale_y), .cfg_pool(cfg_pool),
      .cfg_num_lay(cfg_num_lay), .layer_idx(layer_idx),
      .busy(busy), .all_done(all_done)
   );

   always #5 clk = ~clk;

   logic [127:0] mem [256];
   int checks = 0;
   int errors = 0;

   logic [31:0] obs_reads [$];
   desc_t       obs_desc [$];
   cfg_t        obs_cfg [$];
   int          lat_desc [$];
   int          lat_cfg [$];
   int          req_rise [$];
   int          cfg_cyc [$];
   int          lat_req, lat_done, n_alldone, unstable, timeout;

   logic [31:0] exp_reads [$];
   desc_t       exp_desc [$];
   int          exp_cfg [$];

   // Reference: read slots in order until a zero slot or the last slot.
   task automatic build_model();
      exp_reads.delete();
      exp_desc.delete();
      exp_cfg.delete();
      for (int i = 0; i < 256; i++) begin
         exp_reads.push_back(CFG_ADDR + 32'(i) * 32'd16);
         if (mem[i] == '0) break;
         for (int d = 0; d < 4; d++)
            exp_desc.push_back({2'(d),
                                BASES[d] + 32'(i) * 32'(LENS[d]),
                                LENS[d]});
         exp_cfg.push_back(i);
      end
   endtask

   function automatic logic [127:0] rnd_word();
      logic [127:0] w;
      w = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (w == '0) w = 128'd1;
      return w;
   endfunction

   // Drives start, then plays DDR responder, DMA sink and layer engine.
   task automatic run_seq(input int stall, input bit early,
                          input int budget);
      int    cyc = 0;
      int    cnt = 0;
      int    slot = 0;
      int    stall_left = stall;
      int    done_cnt = -1;
      int    rsp_cyc = -100;
      int    hs_cyc = -100;
      int    tail = -1;
      bit    pend = 0;
      bit    prev_hold = 0;
      bit    prev_req = 0;
      bit    armed = 1;
      bit    want_desc = 0;
      bit    req_seen = 0;
      desc_t held = '0;
      desc_t cur;
      logic [31:0] off;
      obs_reads.delete(); obs_desc.delete(); obs_cfg.delete();
      lat_desc.delete(); lat_cfg.delete();
      req_rise.delete(); cfg_cyc.delete();
      lat_req = -1; lat_done = -1;
      n_alldone = 0; unstable = 0; timeout = 0;
      @(posedge clk); #1;
      start = 1'b1;
      while (tail != 0) begin
         @(posedge clk); #1;
         cyc++;
         start = 1'b0;
         layer_done = 1'b0;
         if (cyc > budget) begin
            timeout = 1;
            break;
         end
         cur = {bus.desc_type, bus.desc_addr, bus.desc_len};
         if (bus.rd_req_valid && !prev_req) req_rise.push_back(cyc);
         if (bus.rd_req_valid && !req_seen) begin
            req_seen = 1;
            lat_req = cyc;
         end
         prev_req = bus.rd_req_valid;
         if (all_done) begin
            n_alldone++;
            lat_done = cyc - rsp_cyc;
            tail = 3;
         end
         if (bus.desc_valid && want_desc) begin
            lat_desc.push_back(cyc - rsp_cyc);
            want_desc = 0;
         end
         if (cfg_valid) begin
            obs_cfg.push_back({cfg_word, cfg_stride, cfg_pool_valifm,
                               cfg_bias_y, cfg_scale_y, cfg_pool,
                               cfg_num_lay, layer_idx});
            cfg_cyc.push_back(cyc);
            lat_cfg.push_back(cyc - hs_cyc);
            armed = 1;
            if (!early) done_cnt = $urandom_range(0, 3);
         end
         if (prev_hold && (!bus.desc_valid || cur !== held)) unstable++;
         if (done_cnt == 0) begin
            layer_done = 1'b1;
            done_cnt = -1;
         end else if (done_cnt > 0) begin
            done_cnt--;
         end
         if (early && armed && bus.desc_valid) begin
            layer_done = 1'b1;
            armed = 0;
         end
         bus.rd_rsp_valid = 1'b0;
         bus.rd_rsp_data = '0;
         if (pend) begin
            if (cnt == 0) begin
               bus.rd_rsp_valid = 1'b1;
               bus.rd_rsp_data = mem[slot];
               pend = 0;
               rsp_cyc = cyc;
               want_desc = (mem[slot] != '0);
            end else begin
               cnt--;
            end
         end
         bus.rd_req_ready = 1'($urandom_range(0, 1));
         if (bus.rd_req_valid && bus.rd_req_ready) begin
            obs_reads.push_back(bus.rd_req_addr);
            off = bus.rd_req_addr - CFG_ADDR;
            slot = int'(off[11:4]);
            pend = 1;
            cnt = $urandom_range(0, 3);
         end
         if (bus.desc_valid && stall > 0) begin
            bus.desc_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
         end else begin
            bus.desc_ready = 1'($urandom_range(0, 1));
         end
         if (bus.desc_valid && bus.desc_ready) begin
            obs_desc.push_back(cur);
            hs_cyc = cyc;
            stall_left = stall;
         end
         prev_hold = bus.desc_valid && !bus.desc_ready;
         held = cur;
         if (tail > 0) tail--;
      end
      bus.rd_req_ready = 1'b0;
      bus.rd_rsp_valid = 1'b0;
      bus.desc_ready = 1'b0;
      layer_done = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy got %b want 0", busy);
      end
      checks++;
      if (all_done !== 1'b0) begin
         errors++; $display("FAIL reset_all_done got %b want 0", all_done);
      end
      checks++;
      if ({bus.rd_req_valid, bus.desc_valid, cfg_valid} !== 3'b000) begin
         errors++;
         $display("FAIL reset_valids got %b want 000",
                  {bus.rd_req_valid, bus.desc_valid, cfg_valid});
      end
      checks++;
      if (layer_idx !== 8'd0) begin
         errors++; $display("FAIL reset_idx got %0d want 0", layer_idx);
      end
      checks++;
      if (cfg_word !== 128'd0) begin
         errors++; $display("FAIL reset_word got %h want 0", cfg_word);
      end
      checks++;
      if ({bus.desc_type, bus.desc_addr, bus.desc_len} !== 58'd0) begin
         errors++;
         $display("FAIL reset_desc got %h want 0",
                  {bus.desc_type, bus.desc_addr, bus.desc_len});
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      desc_t want [4];
      want[0] = {2'd0, 32'h0810_0000, 24'h80_0000};
      want[1] = {2'd1, 32'h0890_0000, 24'h10_0000};
      want[2] = {2'd2, 32'h08A0_0000, 24'h80_0000};
      want[3] = {2'd3, 32'h0920_0000, 24'h10_0000};
      foreach (mem[i]) mem[i] = '0;
      mem[0] = {79'h5_0A0B_0C0D_0E0F_1234, 9'd3, 8'd7, 20'd1, 8'd0,
                1'b1, 3'd2};
      run_seq(0, 0, 2000);
      checks++;
      if (timeout !== 0) begin
         errors++; $display("FAIL basic_timeout got %0d want 0", timeout);
      end
      checks++;
      if (lat_req !== 1) begin
         errors++; $display("FAIL basic_start_lat got %0d want 1", lat_req);
      end
      checks++;
      if (obs_reads.size() !== 2) begin
         errors++;
         $display("FAIL basic_nreads got %0d want 2", obs_reads.size());
      end else begin
         checks++;
         if (obs_reads[0] !== 32'h0800_0000 ||
             obs_reads[1] !== 32'h0800_0010) begin
            errors++;
            $display("FAIL basic_reads got %h %h want 08000000 08000010",
                     obs_reads[0], obs_reads[1]);
         end
      end
      checks++;
      if (obs_desc.size() !== 4) begin
         errors++;
         $display("FAIL basic_ndesc got %0d want 4", obs_desc.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_desc[i] !== want[i]) begin
               errors++;
               $display("FAIL basic_desc%0d got %h want %h",
                        i, obs_desc[i], want[i]);
            end
         end
      end
      checks++;
      if (obs_cfg.size() !== 1) begin
         errors++;
         $display("FAIL basic_ncfg got %0d want 1", obs_cfg.size());
      end else begin
         checks++;
         if ({obs_cfg[0].stride, obs_cfg[0].valifm, obs_cfg[0].bias,
              obs_cfg[0].scale, obs_cfg[0].pool, obs_cfg[0].num} !==
             {3'd2, 1'b1, 8'd0, 20'd1, 8'd7, 9'd3}) begin
            errors++;
            $display("FAIL basic_fields got %0d %0d %0d %0d %0d %0d want 2 1 0 1 7 3",
                     obs_cfg[0].stride, obs_cfg[0].valifm, obs_cfg[0].bias,
                     obs_cfg[0].scale, obs_cfg[0].pool, obs_cfg[0].num);
         end
         checks++;
         if (lat_cfg[0] !== 1) begin
            errors++; $display("FAIL basic_cfg_lat got %0d want 1", lat_cfg[0]);
         end
      end
      checks++;
      if (lat_desc.size() !== 1 || lat_desc[0] !== 1) begin
         errors++;
         $display("FAIL basic_desc_lat got %0d entries want one of 1",
                  lat_desc.size());
      end
      checks++;
      if (n_alldone !== 1 || busy !== 1'b0 || layer_idx !== 8'd1) begin
         errors++;
         $display("FAIL basic_end got done=%0d busy=%b idx=%0d want 1 0 1",
                  n_alldone, busy, layer_idx);
      end
   endtask

   task automatic test_zero_slot();
      foreach (mem[i]) mem[i] = '0;
      run_seq(0, 0, 500);
      checks++;
      if (obs_reads.size() !== 1 || obs_desc.size() !== 0 ||
          obs_cfg.size() !== 0) begin
         errors++;
         $display("FAIL zero_counts got r=%0d d=%0d c=%0d want 1 0 0",
                  obs_reads.size(), obs_desc.size(), obs_cfg.size());
      end
      checks++;
      if (n_alldone !== 1 || lat_done !== 2) begin
         errors++;
         $display("FAIL zero_done got n=%0d lat=%0d want 1 2",
                  n_alldone, lat_done);
      end
   endtask

   task automatic test_desc_stall();
      foreach (mem[i]) mem[i] = rnd_word();
      mem[3] = '0;
      build_model();
      run_seq(5, 0, 3000);
      checks++;
      if (timeout !== 0 || unstable !== 0) begin
         errors++;
         $display("FAIL stall_hold got timeout=%0d unstable=%0d want 0 0",
                  timeout, unstable);
      end
      checks++;
      if (obs_desc.size() !== 12) begin
         errors++;
         $display("FAIL stall_ndesc got %0d want 12", obs_desc.size());
      end else begin
         checks++;
         if (obs_desc[8].a !== 32'h0910_0000) begin
            errors++;
            $display("FAIL stall_l2_act got %h want 09100000", obs_desc[8].a);
         end
         for (int i = 0; i < 12; i++) begin
            checks++;
            if (obs_desc[i] !== exp_desc[i]) begin
               errors++;
               $display("FAIL stall_desc%0d got %h want %h",
                        i, obs_desc[i], exp_desc[i]);
            end
         end
      end
   endtask

   task automatic test_early_done();
      foreach (mem[i]) mem[i] = rnd_word();
      mem[2] = '0;
      build_model();
      run_seq(0, 1, 2000);
      checks++;
      if (timeout !== 0 || n_alldone !== 1) begin
         errors++;
         $display("FAIL early_end got timeout=%0d done=%0d want 0 1",
                  timeout, n_alldone);
      end
      checks++;
      if (req_rise.size() !== 3 || cfg_cyc.size() !== 2) begin
         errors++;
         $display("FAIL early_counts got req=%0d cfg=%0d want 3 2",
                  req_rise.size(), cfg_cyc.size());
      end else begin
         checks++;
         if (req_rise[1] - cfg_cyc[0] !== 2) begin
            errors++;
            $display("FAIL early_gap got %0d want 2",
                     req_rise[1] - cfg_cyc[0]);
         end
      end
      checks++;
      if (obs_reads !== exp_reads) begin
         errors++;
         $display("FAIL early_reads got %0d reads want %0d",
                  obs_reads.size(), exp_reads.size());
      end
   endtask

   task automatic test_rst_mid();
      bit bad = 0;
      foreach (mem[i]) mem[i] = '0;
      mem[0] = rnd_word();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      bus.rd_req_ready = 1'b1;
      @(posedge clk); #1;
      bus.rd_req_ready = 1'b0;
      checks++;
      if (busy !== 1'b1 || bus.rd_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_wait got busy=%b req=%b want 1 0",
                  busy, bus.rd_req_valid);
      end
      rst = 1'b1;
      bus.rd_rsp_valid = 1'b1;
      bus.rd_rsp_data = mem[0];
      @(posedge clk); #1;
      rst = 1'b0;
      bus.rd_rsp_valid = 1'b0;
      bus.rd_rsp_data = '0;
      checks++;
      if (cfg_word !== 128'd0 || busy !== 1'b0 || layer_idx !== 8'd0) begin
         errors++;
         $display("FAIL rstmid_state got word=%h busy=%b idx=%0d want 0 0 0",
                  cfg_word, busy, layer_idx);
      end
      repeat (3) begin
         @(posedge clk); #1;
         if (busy || bus.desc_valid || cfg_valid) bad = 1;
      end
      checks++;
      if (bad !== 1'b0) begin
         errors++; $display("FAIL rstmid_idle got activity=%b want 0", bad);
      end
      run_seq(0, 0, 1000);
      checks++;
      if (obs_reads.size() !== 2 || obs_reads[0] !== CFG_ADDR ||
          obs_desc.size() !== 4 || n_alldone !== 1) begin
         errors++;
         $display("FAIL rstmid_restart got r=%0d d=%0d done=%0d want 2 4 1",
                  obs_reads.size(), obs_desc.size(), n_alldone);
      end
   endtask

   task automatic test_random();
      int n;
      for (int r = 0; r < 3; r++) begin
         n = $urandom_range(1, 6);
         foreach (mem[i]) mem[i] = rnd_word();
         mem[n] = '0;
         build_model();
         run_seq($urandom_range(0, 2), r == 1, 4000);
         checks++;
         if (timeout !== 0 || n_alldone !== 1) begin
            errors++;
            $display("FAIL rand%0d_end got timeout=%0d done=%0d want 0 1",
                     r, timeout, n_alldone);
         end
         checks++;
         if (obs_reads !== exp_reads) begin
            errors++;
            $display("FAIL rand%0d_reads got %0d want %0d",
                     r, obs_reads.size(), exp_reads.size());
         end
         checks++;
         if (obs_desc !== exp_desc) begin
            errors++;
            $display("FAIL rand%0d_descs got %0d want %0d",
                     r, obs_desc.size(), exp_desc.size());
         end
         checks++;
         if (obs_cfg.size() !== n) begin
            errors++;
            $display("FAIL rand%0d_ncfg got %0d want %0d",
                     r, obs_cfg.size(), n);
         end else begin
            for (int i = 0; i < n; i++) begin
               checks++;
               if (obs_cfg[i].w !== mem[exp_cfg[i]] ||
                   obs_cfg[i].idx !== 8'(exp_cfg[i])) begin
                  errors++;
                  $display("FAIL rand%0d_cfg%0d got %h idx %0d want %h idx %0d",
                           r, i, obs_cfg[i].w, obs_cfg[i].idx,
                           mem[exp_cfg[i]], exp_cfg[i]);
               end
            end
         end
      end
   endtask

   task automatic test_all_slots();
      int bad_lat = 0;
      logic [127:0] w;
      foreach (mem[i]) mem[i] = rnd_word();
      build_model();
      run_seq(0, 0, 60000);
      checks++;
      if (timeout !== 0 || n_alldone !== 1) begin
         errors++;
         $display("FAIL all_end got timeout=%0d done=%0d want 0 1",
                  timeout, n_alldone);
      end
      checks++;
      if (obs_reads.size() !== 256) begin
         errors++;
         $display("FAIL all_nreads got %0d want 256", obs_reads.size());
      end
      checks++;
      if (obs_reads !== exp_reads[0:255]) begin
         errors++; $display("FAIL all_reads got %0d addrs want 256 in order",
                            obs_reads.size());
      end
      checks++;
      if (layer_idx !== 8'd255 || busy !== 1'b0) begin
         errors++;
         $display("FAIL all_final got idx=%0d busy=%b want 255 0",
                  layer_idx, busy);
      end
      checks++;
      if (obs_desc.size() !== 1024) begin
         errors++;
         $display("FAIL all_ndesc got %0d want 1024", obs_desc.size());
      end else begin
         for (int i = 0; i < 1024; i++) begin
            checks++;
            if (obs_desc[i] !== exp_desc[i]) begin
               errors++;
               $display("FAIL all_desc%0d got %h want %h",
                        i, obs_desc[i], exp_desc[i]);
            end
         end
      end
      checks++;
      if (obs_cfg.size() !== 256) begin
         errors++;
         $display("FAIL all_ncfg got %0d want 256", obs_cfg.size());
      end else begin
         for (int i = 0; i < 256; i++) begin
            w = mem[i];
            checks++;
            if (obs_cfg[i] !== {w, w[2:0], w[3], w[11:4], w[31:12],
                                w[39:32], w[48:40], 8'(i)}) begin
               errors++;
               $display("FAIL all_cfg%0d got %h want word %h idx %0d",
                        i, obs_cfg[i], w, i);
            end
         end
      end
      foreach (lat_desc[i]) if (lat_desc[i] != 1) bad_lat++;
      foreach (lat_cfg[i]) if (lat_cfg[i] != 1) bad_lat++;
      checks++;
      if (bad_lat !== 0 || lat_desc.size() !== 256) begin
         errors++;
         $display("FAIL all_latency got %0d bad of %0d want 0 of 256",
                  bad_lat, lat_desc.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      layer_done = 1'b0;
      bus.rd_req_ready = 1'b0;
      bus.rd_rsp_valid = 1'b0;
      bus.rd_rsp_data = '0;
      bus.desc_ready = 1'b0;
      test_reset();
      test_basic();
      test_zero_slot();
      test_desc_stall();
      test_early_done();
      test_rst_mid();
      test_random();
      test_all_slots();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ddr_layer_cfg_fetch.md
Name: ddr_layer_cfg_fetch

Overview:
- Synthesizable front end of the memory controller; reads the per-layer config table that initialisation places at CFG_ADDR in DDR (256 slots, one PORT_DATAWIDTH word each).
- Decodes each slot into layer config fields and emits four DMA read descriptors per layer: ACT, FLGACT, WEI, FLGWEI.
- Waits for the layer to finish, then advances to the next slot. A slot holding all zeros terminates the sequence.

Parameters:
- ADDR_W, 32, DDR byte address width
- DATA_W, 128, read data width (= PORT_DATAWIDTH)
- LEN_W, 24, descriptor length width in bytes
- CFG_ADDR, 32'h0800_0000, byte address of config slot 0
- ACT_BASE, 32'h0810_0000, layer-0 ACT base
- FLGACT_BASE, 32'h0890_0000, layer-0 FLGACT base
- WEI_BASE, 32'h08A0_0000, layer-0 WEI base
- FLGWEI_BASE, 32'h0920_0000, layer-0 FLGWEI base
- ACT_LEN, 24'h80_0000, ACT bytes per layer (2^19 words x 16 B)
- FLG_LEN, 24'h10_0000, flag bytes per layer (2^16 words x 16 B), used for FLGACT and FLGWEI
- WEI_LEN, 24'h80_0000, WEI bytes per layer
- MAX_LAYERS, 256, number of config slots

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; starts the fetch sequence at slot 0
- rd_req_valid  out  1  config-word read request
- rd_req_ready  in  1  read request accepted
- rd_req_addr  out  ADDR_W  byte address of the request
- rd_rsp_valid  in  1  read data valid
- rd_rsp_data  in  DATA_W  read data
- desc_valid  out  1  DMA descriptor valid
- desc_ready  in  1  DMA descriptor accepted
- desc_type  out  2  0=ACT, 1=FLGACT, 2=WEI, 3=FLGWEI
- desc_addr  out  ADDR_W  region start byte address
- desc_len  out  LEN_W  region length in bytes
- cfg_valid  out  1  one-cycle pulse; decoded fields are valid
- cfg_word  out  DATA_W  registered raw config word
- cfg_stride  out  3  cfg_word[2:0]
- cfg_pool_valifm  out  1  cfg_word[3]
- cfg_bias_y  out  8  cfg_word[11:4]
- cfg_scale_y  out  20  cfg_word[31:12]
- cfg_pool  out  8  cfg_word[39:32]
- cfg_num_lay  out  9  cfg_word[48:40]
- layer_idx  out  8  current slot index
- layer_done  in  1  pulse; the current layer has completed
- busy  out  1  high in every state except IDLE
- all_done  out  1  one-cycle pulse at end of sequence

Behaviour:
- Interface: one clock domain, clk. Reset is synchronous and active-high on rst.
- Reset: state=IDLE; layer_idx=0; cfg_word=0. All valid/pulse outputs, busy and all_done are 0. All descriptor outputs are 0.
- A rst assertion in any state wins over every other input. Any outstanding response or descriptor is dropped. Descriptor outputs go to 0 in the next cycle.
- IDLE: on start, set layer_idx=0 and go to CFG_REQ. start is ignored in every other state.
- CFG_REQ:
  - rd_req_valid=1, rd_req_addr = CFG_ADDR + {layer_idx,4'b0}.
  - valid stays high and addr stays stable until rd_req_ready. Go to CFG_WAIT on the handshake cycle.
- CFG_WAIT:
  - Only one request is ever outstanding. On rd_rsp_valid, latch rd_rsp_data into cfg_word.
  - If the data is all zeros, go to FINISH. Otherwise go to DESC with desc counter d=0.
  - rd_rsp_valid in any other state is ignored.
- DESC:
  - desc_valid=1, desc_type=d.
  - desc_addr = BASE[d] + layer_idx x LEN[d]. Compute at ADDR_W width; overflow wraps modulo 2^ADDR_W.
  - desc_len = LEN[d].
  - Outputs are registered and held stable while desc_valid && !desc_ready.
  - On handshake: if d<3, d=d+1 and present the next descriptor in the following cycle (no bubble required). If d=3, go to CFG_OUT.
- CFG_OUT:
  - Single cycle; cfg_valid=1.
  - Decoded outputs are combinational slices of cfg_word and are valid from this cycle until the next cfg_word latch.
  - Go to RUN.
- RUN:
  - Wait for layer_done. A layer_done pulse arriving earlier (during DESC/CFG_OUT) is captured in a sticky flag and is consumed on entering RUN.
  - On done: if layer_idx=MAX_LAYERS-1, go to FINISH. Otherwise layer_idx+1 and go to CFG_REQ.
- FINISH: all_done=1 for one cycle, then IDLE. layer_idx holds its last value.
- Latency: start to rd_req_valid is 1 cycle. Response to first desc_valid is 1 cycle. Fourth descriptor handshake to cfg_valid is 1 cycle.

Test Plan:
- Slot0 = 82-bit {3,2,0,15,31,1,15,0,3,7,1,0,1,2}, slot1=0. Pulse start.
  -> rd_req_addr=0800_0000.
  -> 4 descriptors: (0,0810_0000,80_0000), (1,0890_0000,10_0000), (2,08A0_0000,80_0000), (3,0920_0000,10_0000).
  -> cfg_valid with stride=2, pool_valifm=1, bias_y=0, scale_y=1.
  -> After layer_done: request at 0800_0010, zero word, all_done, IDLE.
- Slot0 = 0. Start -> no descriptors, no cfg_valid; all_done 2 cycles after the response.
- desc_ready low 5 cycles on each descriptor -> desc_* held stable, exactly 4 handshakes. Layer 2 ACT addr = 0810_0000 + 2 x 80_0000 = 0910_0000.
- layer_done pulsed during DESC -> no hang; next CFG_REQ issued right after CFG_OUT/RUN.
- All 256 slots nonzero -> 256 layers, final layer_idx=255, all_done, no 257th read.
- rst pulsed in CFG_WAIT with rd_rsp_valid in the same cycle -> cfg_word=0, IDLE, busy=0. The next start begins at slot 0.
